// File: rtl/div_seq_signed_pkg.sv
// Shared definitions for the sequential signed divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = DIV_IDLE,
    S_CALC = DIV_CALC,
    S_DONE = DIV_DONE
  } div_state_e;
endpackage

// File: rtl/div_seq_signed_if.sv
// Request/response bundle between the control unit (master) and the divider (slave).
interface div_seq_signed_if import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) ();
  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             div_fim;
  logic             div_by_zero;

  modport master (output div_start, dividend, divisor,
                  input  lo, hi, div_fim, div_by_zero);
  modport slave  (input  div_start, dividend, divisor,
                  output lo, hi, div_fim, div_by_zero);
endinterface

// File: rtl/div_seq_signed_abs_neg.sv
// Conditional two's-complement negate; doubles as abs() when neg_i is the sign bit.
module div_abs_neg #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);
  // INT_MIN maps to itself, which is the correct unsigned magnitude and the wrapped result.
  assign res_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/div_seq_signed.sv
// Multicycle signed divider: restoring division on magnitudes, then sign fix-up.
// Quotient to lo, remainder to hi, one-cycle div_fim, div_by_zero alongside it.
module div_seq_signed import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic              clock,
  input logic              reset,
  div_seq_signed_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_INIT = cnt_t'(WIDTH - 1);

  div_state_e       state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;

  logic [WIDTH-1:0] a_abs, b_abs, lo_fix, hi_fix, rem_nx, quo_nx;
  logic [WIDTH:0]   rem_sh, trial;
  logic             ge;

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.val_i(bus.dividend), .neg_i(bus.dividend[WIDTH-1]), .res_o(a_abs));
  div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.val_i(bus.divisor),  .neg_i(bus.divisor[WIDTH-1]),  .res_o(b_abs));
  div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.val_i(quo_nx),       .neg_i(qneg_q),                .res_o(lo_fix));
  div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.val_i(rem_nx),       .neg_i(rneg_q),                .res_o(hi_fix));

  // One restoring step: shift {rem,quo} left, keep the trial difference if it did not go negative.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    ge     = ~trial[WIDTH];
    rem_nx = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], ge};
  end

  // Next-state and datapath updates; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: if (bus.div_start) begin
        if (bus.divisor == '0) begin
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          dbz_d   = 1'b0;
          dvs_d   = b_abs;
          quo_d   = a_abs;
          rem_d   = '0;
          qneg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          rneg_d  = bus.dividend[WIDTH-1];
          cnt_d   = CNT_INIT;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == '0) begin
          lo_d    = lo_fix;
          hi_d    = hi_fix;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      S_DONE: begin
        dbz_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any divide in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.lo          = lo_q;
  assign bus.hi          = hi_q;
  assign bus.div_fim     = (state_q == S_DONE);
  assign bus.div_by_zero = (state_q == S_DONE) && dbz_q;
endmodule
